// File: rtl/nibble_serial_comparator.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB nibble first through an
// external four-bit comparator and stops at the first unequal nibble.
module nibble_serial_comparator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             err
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [3:0]       cmp_a_r, cmp_a_s;
    logic [3:0]       cmp_b_r, cmp_b_s;
    logic             done_r, done_s;
    logic             eq_r, eq_s;
    logic             gt_r, gt_s;
    logic             lt_r, lt_s;
    logic             err_r, err_s;
    logic [2:0]       flags_s;

    function automatic logic [3:0] nib(input logic [WIDTH-1:0] v, input logic [IW-1:0] i);
        logic [WIDTH-1:0] sh;
        sh = v >> {i, 2'b00};
        return sh[3:0];
    endfunction

    assign flags_s = {cmp_gt, cmp_lt, cmp_eq};

    // State and datapath registers; everything visible outside comes straight from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            idx_r   <= '0;
            cmp_a_r <= 4'h0;
            cmp_b_r <= 4'h0;
            done_r  <= 1'b0;
            eq_r    <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            idx_r   <= idx_s;
            cmp_a_r <= cmp_a_s;
            cmp_b_r <= cmp_b_s;
            done_r  <= done_s;
            eq_r    <= eq_s;
            gt_r    <= gt_s;
            lt_r    <= lt_s;
            err_r   <= err_s;
        end
    end

    // Next-state logic; the comparator nibbles are preloaded so they are valid for each RUN cycle.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        idx_s   = idx_r;
        cmp_a_s = cmp_a_r;
        cmp_b_s = cmp_b_r;
        done_s  = 1'b0;
        eq_s    = eq_r;
        gt_s    = gt_r;
        lt_s    = lt_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = a;
                    b_s     = b;
                    idx_s   = IW'(N - 1);
                    cmp_a_s = nib(a, IW'(N - 1));
                    cmp_b_s = nib(b, IW'(N - 1));
                    eq_s    = 1'b0;
                    gt_s    = 1'b0;
                    lt_s    = 1'b0;
                    err_s   = 1'b0;
                    state_s = RUN;
                end else begin
                    cmp_a_s = 4'h0;
                    cmp_b_s = 4'h0;
                end
            end
            RUN: begin
                // Any exit from RUN returns the comparator inputs to zero.
                cmp_a_s = 4'h0;
                cmp_b_s = 4'h0;
                case (flags_s)
                    3'b100: begin
                        gt_s    = 1'b1;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end
                    3'b010: begin
                        lt_s    = 1'b1;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end
                    3'b001: begin
                        if (idx_r == IW'(0)) begin
                            eq_s    = 1'b1;
                            done_s  = 1'b1;
                            state_s = IDLE;
                        end else begin
                            idx_s   = idx_r - IW'(1);
                            cmp_a_s = nib(a_r, idx_s);
                            cmp_b_s = nib(b_r, idx_s);
                        end
                    end
                    default: begin
                        err_s   = 1'b1;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end
                endcase
            end
            default: begin
                state_s = IDLE;
                cmp_a_s = 4'h0;
                cmp_b_s = 4'h0;
            end
        endcase
    end

    assign busy   = (state_r == RUN);
    assign cmp_a  = cmp_a_r;
    assign cmp_b  = cmp_b_r;
    assign done   = done_r;
    assign a_eq_b = eq_r;
    assign a_gt_b = gt_r;
    assign a_lt_b = lt_r;
    assign err    = err_r;

endmodule
